// File: rtl/foobar_pkg.sv
// -----------------------------------------------------------------------------
// foobar_pkg
//   Shared types and helpers for the multi-channel strobe/event counter.
//   - NCH_MAX : upper bound on the channel count of foobar_multi
//   - CNT_W   : pulse counter width, PER_W : period/phase width
//   - per_t, cnt_t : period and counter types
//   - next_count() : counter increment with wrap/saturate and overflow flag
// -----------------------------------------------------------------------------
package foobar_pkg;

    localparam int NCH_MAX = 16;
    localparam int CNT_W   = 8;
    localparam int PER_W   = 8;

    typedef logic [PER_W-1:0] per_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Result of one counter increment: overflow indication plus new value.
    typedef struct packed {
        logic ovf;
        cnt_t cnt;
    } cnt_res_t;

    // Counter at its maximum either wraps to zero or sticks at max; either way
    // the overflow indication is raised.
    function automatic cnt_res_t next_count(input cnt_t cnt, input logic sat);
        cnt_res_t res;
        if (cnt == '1) begin
            res.ovf = 1'b1;
            res.cnt = sat ? cnt : '0;
        end else begin
            res.ovf = 1'b0;
            res.cnt = cnt + cnt_t'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/foobar_chan.sv
// -----------------------------------------------------------------------------
// foobar_chan
//   One event channel: programmable period, phase counter, registered 1-cycle
//   pulse every PERIOD enabled cycles, pulse counter with sticky overflow.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     en           advance enable (low = hold, pulse forced low)
//     clr          synchronous clear of phase/count/ovf/pulse (period kept)
//     cfg_we       period write strobe already decoded for this channel
//     cfg_period   new period value (0 disables the channel)
//     pulse        registered event strobe
//     count        pulse count
//     ovf          sticky counter overflow
// -----------------------------------------------------------------------------
module foobar_chan
    import foobar_pkg::*;
#(
    parameter bit   SAT     = 1'b0,
    parameter per_t DEF_PER = per_t'(1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic cfg_we,
    input  per_t cfg_period,
    output logic pulse,
    output cnt_t count,
    output logic ovf
);

    per_t period_q, period_d;
    per_t phase_q,  phase_d;
    cnt_t count_q,  count_d;
    logic ovf_q,    ovf_d;
    logic pulse_q,  pulse_d;

    per_t     period_last;
    cnt_res_t cnt_nxt;

    // Only meaningful when period_q != 0; the use below is guarded, so the
    // underflow for a disabled channel never matters.
    assign period_last = period_q - per_t'(1);
    assign cnt_nxt     = next_count(count_q, SAT);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        period_d = period_q;
        phase_d  = phase_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        pulse_d  = 1'b0;

        // A period write lands even during a clear.
        if (cfg_we) begin
            period_d = cfg_period;
        end

        if (clr) begin
            phase_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (cfg_we) begin
            // Restart the phase; any event due this cycle is dropped.
            phase_d = '0;
        end else if (en && (period_q != '0)) begin
            if (phase_q == period_last) begin
                phase_d = '0;
                pulse_d = 1'b1;
                count_d = cnt_nxt.cnt;
                ovf_d   = ovf_q | cnt_nxt.ovf;
            end else begin
                phase_d = phase_q + per_t'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= DEF_PER;
            phase_q  <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            phase_q  <= phase_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/foobar_multi.sv
// -----------------------------------------------------------------------------
// foobar_multi
//   NCH independent event channels, each pulsing every PERIOD enabled cycles
//   and counting its pulses. Periods are runtime-programmable via cfg_*.
//   Counter and period widths follow foobar_pkg.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     en           advance enable for all channels
//     clr          synchronous clear of phases/counts/ovf/pulses
//     cfg_we       period write strobe
//     cfg_ch       channel addressed by cfg_we (values >= NCH are ignored)
//     cfg_period   new period value
//     pulse        per-channel registered event strobe
//     count        per-channel counts, channel i at [i*CNT_W +: CNT_W]
//     ovf          per-channel sticky overflow
// -----------------------------------------------------------------------------
module foobar_multi
    import foobar_pkg::*;
#(
    parameter int                NCH     = 4,
    parameter int                CNT_W   = foobar_pkg::CNT_W,
    parameter int                PER_W   = foobar_pkg::PER_W,
    parameter bit                SAT     = 1'b0,
    parameter per_t [NCH-1:0]    DEF_PER = {per_t'(5), per_t'(3), per_t'(2), per_t'(1)},
    localparam int               CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [PER_W-1:0]     cfg_period,
    output logic [NCH-1:0]       pulse,
    output logic [NCH*CNT_W-1:0] count,
    output logic [NCH-1:0]       ovf
);

    logic [NCH-1:0] ch_we;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // Out-of-range addresses simply match no channel.
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        foobar_chan #(
            .SAT     (SAT),
            .DEF_PER (DEF_PER[i])
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .clr        (clr),
            .cfg_we     (ch_we[i]),
            .cfg_period (cfg_period),
            .pulse      (pulse[i]),
            .count      (count[i*CNT_W +: CNT_W]),
            .ovf        (ovf[i])
        );
    end

endmodule
